// File: rtl/soc_map.sv
// Shared SoC address map: region bases/masks, slave indices and decoder FSM encoding.
package soc_map;

    localparam int unsigned NUM_SLAVES = 3;

    localparam int unsigned BOOTROM = 0;
    localparam int unsigned SRAM    = 1;
    localparam int unsigned IO      = 2;

    localparam logic [31:0] BOOTROM_BASE = 32'hb000_0000;
    localparam logic [31:0] BOOTROM_MASK = 32'hffff_8000;
    localparam logic [31:0] SRAM_BASE    = 32'hb000_8000;
    localparam logic [31:0] SRAM_MASK    = 32'hffff_8000;
    localparam logic [31:0] IO_BASE      = 32'hc000_0000;
    localparam logic [31:0] IO_MASK      = 32'hffff_0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StErr  = 2'd2
    } state_e;

    function automatic logic in_region(input logic [31:0] addr, input logic [31:0] base,
                                       input logic [31:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/soc_addr_decode.sv
// Combinational address decoder: one-hot slave select plus a mapped/valid flag.
module soc_addr_decode
    import soc_map::*;
(
    input  logic [31:0] addr,
    output logic [2:0]  sel,
    output logic        valid
);

    always_comb begin
        sel          = '0;
        sel[BOOTROM] = in_region(addr, BOOTROM_BASE, BOOTROM_MASK);
        sel[SRAM]    = in_region(addr, SRAM_BASE, SRAM_MASK);
        sel[IO]      = in_region(addr, IO_BASE, IO_MASK);
        valid        = |sel;
    end

endmodule

// File: rtl/wb_decoder.sv
// Single-master, three-slave Wishbone interconnect with bus-error termination for
// unmapped addresses and slave timeouts, plus a sticky exception/fault-address record.
module wb_decoder
    import soc_map::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TIMEOUT_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic [31:0] o_wb_data,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic        o_wb_err,
    output logic [2:0]  o_slv_cyc,
    output logic [2:0]  o_slv_stb,
    output logic        o_slv_we,
    output logic [31:0] o_slv_addr,
    output logic [31:0] o_slv_data,
    input  logic [2:0]  i_slv_ack,
    input  logic [2:0]  i_slv_stall,
    input  logic [95:0] i_slv_data,
    output logic        o_exception,
    output logic [31:0] o_fault_addr,
    input  logic        i_exc_clr
);

    state_e               state_q, state_d;
    logic [2:0]           sel_q, sel_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          fault_q, fault_d;
    logic                 exc_q, exc_d, exc_set;
    logic [2:0]           dec_sel;
    logic                 dec_valid;
    logic                 req, sel_stall, sel_ack;

    soc_addr_decode u_addr_decode (
        .addr  (i_wb_addr),
        .sel   (dec_sel),
        .valid (dec_valid)
    );

    assign o_slv_we     = i_wb_we;
    assign o_slv_addr   = i_wb_addr;
    assign o_slv_data   = i_wb_data;
    assign o_exception  = exc_q;
    assign o_fault_addr = fault_q;
    assign req          = i_wb_cyc & i_wb_stb;
    assign sel_stall    = |(i_slv_stall & dec_sel);
    assign sel_ack      = |(i_slv_ack & sel_q);

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        fault_d    = fault_q;
        exc_set    = 1'b0;
        o_slv_cyc  = '0;
        o_slv_stb  = '0;
        o_wb_ack   = 1'b0;
        o_wb_stall = 1'b0;
        o_wb_err   = 1'b0;
        o_wb_data  = '0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (req) begin
                    if (dec_valid) begin
                        o_slv_stb  = dec_sel;
                        o_slv_cyc  = dec_sel;
                        o_wb_stall = sel_stall;
                        if (!sel_stall) begin
                            sel_d   = dec_sel;
                            addr_d  = i_wb_addr;
                            state_d = StBusy;
                        end
                    end else begin
                        fault_d = i_wb_addr;
                        state_d = StErr;
                    end
                end
            end
            StBusy: begin
                if (!i_wb_cyc) begin
                    // Master abandoned the cycle: drop it silently.
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    o_slv_cyc  = sel_q;
                    o_wb_stall = 1'b1;
                    if (sel_ack) begin
                        o_wb_ack = 1'b1;
                        for (int n = 0; n < NUM_SLAVES; n++) begin
                            if (sel_q[n]) o_wb_data = i_slv_data[32*n +: 32];
                        end
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES)) begin
                        o_wb_err = 1'b1;
                        fault_d  = addr_q;
                        exc_set  = 1'b1;
                        cnt_d    = '0;
                        state_d  = StIdle;
                    end else begin
                        cnt_d = cnt_q + TIMEOUT_W'(1);
                    end
                end
            end
            StErr: begin
                state_d = StIdle;
                if (i_wb_cyc) begin
                    o_wb_err = 1'b1;
                    exc_set  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A new fault outranks a simultaneous clear.
    always_comb begin
        exc_d = exc_q;
        if (i_exc_clr) exc_d = 1'b0;
        if (exc_set)   exc_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            sel_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            fault_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            fault_q <= fault_d;
            exc_q   <= exc_d;
        end
    end

endmodule

// File: tb/tb_wb_decoder.sv
// Directed self-checking bench for wb_decoder with a short timeout (4 cycles).
module tb_wb_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_wb_cyc, i_wb_stb, i_wb_we;
    logic [31:0] i_wb_addr, i_wb_data;
    logic [31:0] o_wb_data;
    logic        o_wb_ack, o_wb_stall, o_wb_err;
    logic [2:0]  o_slv_cyc, o_slv_stb;
    logic        o_slv_we;
    logic [31:0] o_slv_addr, o_slv_data;
    logic [2:0]  i_slv_ack, i_slv_stall;
    logic [95:0] i_slv_data;
    logic        o_exception;
    logic [31:0] o_fault_addr;
    logic        i_exc_clr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_decoder #(
        .TIMEOUT_CYCLES (4),
        .TIMEOUT_W      (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_wb_cyc     (i_wb_cyc),
        .i_wb_stb     (i_wb_stb),
        .i_wb_we      (i_wb_we),
        .i_wb_addr    (i_wb_addr),
        .i_wb_data    (i_wb_data),
        .o_wb_data    (o_wb_data),
        .o_wb_ack     (o_wb_ack),
        .o_wb_stall   (o_wb_stall),
        .o_wb_err     (o_wb_err),
        .o_slv_cyc    (o_slv_cyc),
        .o_slv_stb    (o_slv_stb),
        .o_slv_we     (o_slv_we),
        .o_slv_addr   (o_slv_addr),
        .o_slv_data   (o_slv_data),
        .i_slv_ack    (i_slv_ack),
        .i_slv_stall  (i_slv_stall),
        .i_slv_data   (i_slv_data),
        .o_exception  (o_exception),
        .o_fault_addr (o_fault_addr),
        .i_exc_clr    (i_exc_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_master();
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b0;
        idle_master();
        i_wb_addr   = '0;
        i_wb_data   = '0;
        i_slv_ack   = '0;
        i_slv_stall = '0;
        i_slv_data  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        i_exc_clr   = 1'b0;
        #2;
        check_eq("rst_ack", 32'(o_wb_ack), 32'd0);
        check_eq("rst_err", 32'(o_wb_err), 32'd0);
        check_eq("rst_stall", 32'(o_wb_stall), 32'd0);
        check_eq("rst_slv_cyc", 32'(o_slv_cyc), 32'd0);
        check_eq("rst_exc", 32'(o_exception), 32'd0);
        check_eq("rst_fault", o_fault_addr, 32'd0);
        step();
        step();
        reset = 1'b1;
        step();

        // Bootrom read, ack two cycles after acceptance.
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_addr = 32'hb000_0010;
        #1;
        check_eq("rom_stb", 32'(o_slv_stb), 32'b001);
        check_eq("rom_cyc", 32'(o_slv_cyc), 32'b001);
        check_eq("rom_stall0", 32'(o_wb_stall), 32'd0);
        check_eq("rom_addr_pass", o_slv_addr, 32'hb000_0010);
        step();
        i_wb_stb = 1'b0;
        check_eq("rom_busy_stall", 32'(o_wb_stall), 32'd1);
        check_eq("rom_busy_stb", 32'(o_slv_stb), 32'd0);
        check_eq("rom_busy_cyc", 32'(o_slv_cyc), 32'b001);
        check_eq("rom_noack", 32'(o_wb_ack), 32'd0);
        step();
        i_slv_ack = 3'b001; i_slv_data[31:0] = 32'hdead_beef;
        #1;
        check_eq("rom_ack", 32'(o_wb_ack), 32'd1);
        check_eq("rom_data", o_wb_data, 32'hdead_beef);
        check_eq("rom_err", 32'(o_wb_err), 32'd0);
        step();
        i_slv_ack = '0; idle_master();
        #1;
        check_eq("rom_idle_data", o_wb_data, 32'd0);

        // SRAM write stalled for three cycles.
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
        i_wb_addr = 32'hb000_8004; i_wb_data = 32'h1234_5678; i_slv_stall = 3'b010;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("sram_stalled", 32'(o_wb_stall), 32'd1);
            check_eq("sram_stb_held", 32'(o_slv_stb), 32'b010);
            step();
        end
        i_slv_stall = '0;
        #1;
        check_eq("sram_accept_stall", 32'(o_wb_stall), 32'd0);
        check_eq("sram_we_pass", 32'(o_slv_we), 32'd1);
        check_eq("sram_data_pass", o_slv_data, 32'h1234_5678);
        step();
        i_wb_stb = 1'b0; i_slv_ack = 3'b010; i_slv_data[63:32] = 32'hcafe_0001;
        #1;
        check_eq("sram_ack", 32'(o_wb_ack), 32'd1);
        check_eq("sram_data", o_wb_data, 32'hcafe_0001);
        step();
        i_slv_ack = '0; idle_master();

        // Unmapped read; clear coincides with the error cycle, so set must win.
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_addr = 32'h0000_1000;
        #1;
        check_eq("unm_stb", 32'(o_slv_stb), 32'd0);
        check_eq("unm_stall", 32'(o_wb_stall), 32'd0);
        check_eq("unm_err_early", 32'(o_wb_err), 32'd0);
        step();
        i_wb_stb = 1'b0; i_exc_clr = 1'b1;
        #1;
        check_eq("unm_err", 32'(o_wb_err), 32'd1);
        check_eq("unm_ack", 32'(o_wb_ack), 32'd0);
        step();
        i_exc_clr = 1'b0;
        #1;
        check_eq("unm_err_once", 32'(o_wb_err), 32'd0);
        check_eq("unm_exc_setwins", 32'(o_exception), 32'd1);
        check_eq("unm_fault", o_fault_addr, 32'h0000_1000);
        idle_master(); i_exc_clr = 1'b1;
        step();
        i_exc_clr = 1'b0;
        check_eq("unm_exc_clr", 32'(o_exception), 32'd0);

        // IO slave never acks: error on the 5th cycle after acceptance.
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 32'hc000_0020;
        #1;
        check_eq("io_stb", 32'(o_slv_stb), 32'b100);
        step();
        i_wb_stb = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check_eq("io_no_err_yet", 32'(o_wb_err), 32'd0);
            check_eq("io_busy_stall", 32'(o_wb_stall), 32'd1);
            step();
        end
        #1;
        check_eq("io_timeout_err", 32'(o_wb_err), 32'd1);
        check_eq("io_timeout_ack", 32'(o_wb_ack), 32'd0);
        step();
        check_eq("io_idle_stall", 32'(o_wb_stall), 32'd0);
        check_eq("io_idle_err", 32'(o_wb_err), 32'd0);
        check_eq("io_exc", 32'(o_exception), 32'd1);
        check_eq("io_fault", o_fault_addr, 32'hc000_0020);
        i_wb_stb = 1'b1; i_wb_addr = 32'hb000_0100;
        #1;
        check_eq("post_to_stb", 32'(o_slv_stb), 32'b001);
        step();
        i_wb_stb = 1'b0; i_slv_ack = 3'b001; i_slv_data[31:0] = 32'h0bad_f00d;
        #1;
        check_eq("post_to_ack", 32'(o_wb_ack), 32'd1);
        check_eq("post_to_data", o_wb_data, 32'h0bad_f00d);
        step();
        i_slv_ack = '0; idle_master();

        // Abort after two unacked BUSY cycles; ack arrives with and after the cyc drop.
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_addr = 32'hb000_8010;
        step();
        i_wb_stb = 1'b0;
        step();
        step();
        i_wb_cyc = 1'b0; i_slv_ack = 3'b010;
        #1;
        check_eq("abort_ack", 32'(o_wb_ack), 32'd0);
        check_eq("abort_slv_cyc", 32'(o_slv_cyc), 32'd0);
        check_eq("abort_err", 32'(o_wb_err), 32'd0);
        step();
        check_eq("late_ack", 32'(o_wb_ack), 32'd0);
        check_eq("late_cnt", 32'(dut.cnt_q), 32'd0);
        check_eq("late_state", 32'(dut.state_q), 32'd0);
        i_slv_ack = '0;

        // Asynchronous reset mid-BUSY with a pending slave ack afterwards.
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_addr = 32'hb000_0000;
        step();
        i_wb_stb = 1'b0;
        #1;
        check_eq("pre_rst_cyc", 32'(o_slv_cyc), 32'b001);
        check_eq("pre_rst_exc", 32'(o_exception), 32'd1);
        reset = 1'b0;
        #1;
        check_eq("arst_slv_cyc", 32'(o_slv_cyc), 32'd0);
        check_eq("arst_stall", 32'(o_wb_stall), 32'd0);
        check_eq("arst_exc", 32'(o_exception), 32'd0);
        check_eq("arst_fault", o_fault_addr, 32'd0);
        i_slv_ack = 3'b001;
        step();
        reset = 1'b1;
        #1;
        check_eq("arst_late_ack", 32'(o_wb_ack), 32'd0);
        step();
        check_eq("arst_late_ack2", 32'(o_wb_ack), 32'd0);
        check_eq("arst_err", 32'(o_wb_err), 32'd0);
        i_slv_ack = '0; idle_master();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_decoder.md
# wb_decoder

Single-master, three-slave Wishbone interconnect that sits between the CPU core's bus port and the bootrom, internal SRAM and IO slaves. It decodes each strobe's address, forwards the request to exactly one slave and routes that slave's stall, ack and read data back to the master. Unmapped accesses and slaves that never acknowledge are terminated with a bus-error response. A sticky exception flag and the faulting address are latched for the core.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: cycles allowed in BUSY without ack before the error response.
- TIMEOUT_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  master cycle, strobe, write enable.
- i_wb_addr  in  32  master byte address.
- i_wb_data  in  32  master write data.
- o_wb_data  out  32  read data to master.
- o_wb_ack, o_wb_stall, o_wb_err  out  1 each  master ack, stall, bus error.
- o_slv_cyc, o_slv_stb  out  3  per-slave cyc/stb, one-hot; bit 0 bootrom, bit 1 sram, bit 2 io.
- o_slv_we  out  1  shared write enable.
- o_slv_addr  out  32  shared address.
- o_slv_data  out  32  shared write data.
- i_slv_ack, i_slv_stall  in  3  per-slave ack and stall.
- i_slv_data  in  96  packed read data, slave n at [32n+31:32n].
- o_exception  out  1  sticky fault flag.
- o_fault_addr  out  32  address of the most recent fault.
- i_exc_clr  in  1  clears o_exception.

## Operation
Memory map:
- bootrom: 0xb0000000–0xb0007fff.
- sram: 0xb0008000–0xb000ffff.
- io: 0xc0000000–0xc000ffff.
- Any other address is unmapped.

FSM states are IDLE, BUSY and ERR.
- **IDLE**, cyc&stb, mapped:
  - o_slv_stb[sel] = 1 combinationally; o_wb_stall = i_slv_stall[sel].
  - When the strobe is accepted (stall low), latch sel and go to BUSY.
- **IDLE**, cyc&stb, unmapped:
  - o_wb_stall = 0; no slave strobed.
  - Latch o_fault_addr and go to ERR.
- **BUSY**:
  - o_slv_cyc[sel] = 1; o_wb_stall = 1, so only one transaction is outstanding.
  - o_wb_ack = i_slv_ack[sel]; o_wb_data = the sel slice when ack is high, else 0.
  - On ack, go to IDLE.
  - The counter increments each BUSY cycle without ack. When it reaches TIMEOUT_CYCLES: assert o_wb_err, latch o_fault_addr, set o_exception, clear the counter, go to IDLE.
- **ERR**: o_wb_err = 1 for exactly one cycle, o_exception set, then go to IDLE.
- **cyc drop**: i_wb_cyc low in BUSY or ERR aborts the transaction.
  - State returns to IDLE and the counter clears.
  - No ack or err is forwarded; late slave acks in IDLE are ignored.
- **o_slv_cyc**: the selected bit is also high in IDLE whenever the corresponding o_slv_stb bit is high.
- **Pass-through**: o_slv_we, o_slv_addr and o_slv_data are combinational copies of the master's signals.

## Timing
- **Reset values**: state IDLE; counter 0; o_exception 0; o_fault_addr 0. All slave cyc/stb, o_wb_ack, o_wb_err and o_wb_stall are 0.
- **Zero-latency paths**: stb to slave, stall to master, and ack/data to master are all combinational.
- **Unmapped access**: error arrives exactly 1 cycle after the accepted strobe.
- **Timeout**: error on the cycle the counter reaches TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES+1 cycles after acceptance with no ack.
- **Simultaneous events**:
  - Ack and timeout in the same cycle: ack wins, no err.
  - i_exc_clr and a new fault in the same cycle: set wins.
  - cyc low and ack in the same cycle: no ack forwarded.
- **Reset mid-transaction**: all state clears asynchronously; an outstanding slave ack after reset release is ignored.
- **Outputs**: never ack and err in the same cycle; at most one o_slv_stb bit high.

## Structure
- Shared package/header soc_map holds:
  - base and mask constants for each region;
  - slave index constants BOOTROM=0, SRAM=1, IO=2;
  - state encodings.
- One combinational sub-module, soc_addr_decode: address in; one-hot sel[2:0] and valid out. It is reused by future masters.

## Test plan
- **Bootrom read**: read 0xb0000010, slave 0 acks 2 cycles later with 0xdeadbeef → o_slv_stb=001; master sees ack with data 0xdeadbeef; no err.
- **SRAM write stalled**: write 0xb0008004 with slave 1 stall high 3 cycles → master stall high 3 cycles; stb accepted on cycle 4; ack forwarded.
- **Unmapped access**: read 0x00001000 → no slave strobed; err 1 cycle later; o_exception=1; o_fault_addr=0x00001000; cleared by i_exc_clr.
- **Timeout**: TIMEOUT_CYCLES=4, io slave never acks → err on cycle 5 after acceptance; FSM back in IDLE; next access to bootrom succeeds.
- **Abort and late ack**: cyc dropped in BUSY, then slave acks → no ack forwarded; counter 0; state IDLE.
- **Async reset**: reset asserted mid-BUSY → all outputs 0 immediately; o_exception 0.
